// File: rtl/pc_stack_unit.sv
// Program counter with integrated circular or guarded return stack; one op per en strobe, single-cycle.
// Define PC_STACK_GUARD_EN for a guarded stack: full CALLs and empty RETURNs are refused and flagged.
module pc_stack_unit #(
  parameter int              PC_W         = 9,
  parameter int              STACK_DEPTH  = 2,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [2:0]                       op,
  input  logic [PC_W-1:0]                  jump_addr,
  output logic [PC_W-1:0]                  pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic                             stack_ovf,
  output logic                             stack_unf
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_HOLD     = 3'b000;
  localparam logic [2:0] OP_INC      = 3'b001;
  localparam logic [2:0] OP_SKIP     = 3'b010;
  localparam logic [2:0] OP_GOTO     = 3'b011;
  localparam logic [2:0] OP_CALL     = 3'b100;
  localparam logic [2:0] OP_RETURN   = 3'b101;
  localparam logic [2:0] OP_LOAD_LOW = 3'b110;
  localparam logic [2:0] OP_SOFT_RST = 3'b111;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;

  logic [PC_W-1:0]  pc_inc, pc_skip, pc_masked;
  logic [SP_W-1:0]  sp_inc, sp_dec;
  logic             full, empty;

  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_skip   = pc_q + PC_W'(2);
  // CALL and PCL writes only carry the low bits; the page bit is forced low.
  assign pc_masked = {1'b0, jump_addr[PC_W-2:0]};
  assign sp_inc    = (sp_q == SP_W'(STACK_DEPTH - 1)) ? '0 : sp_q + SP_W'(1);
  assign sp_dec    = (sp_q == '0) ? SP_W'(STACK_DEPTH - 1) : sp_q - SP_W'(1);
  assign full      = (lvl_q == LVL_W'(STACK_DEPTH));
  assign empty     = (lvl_q == '0);

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    lvl_d = lvl_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (en) begin
      case (op)
        OP_HOLD:     pc_d = pc_q;
        OP_INC:      pc_d = pc_inc;
        OP_SKIP:     pc_d = pc_skip;
        OP_GOTO:     pc_d = jump_addr;
        OP_CALL: begin
          pc_d = pc_masked;
`ifdef PC_STACK_GUARD_EN
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push  = 1'b1;
            sp_d  = sp_inc;
            lvl_d = lvl_q + LVL_W'(1);
          end
`else
          // Circular stack: a push when full overwrites the oldest entry.
          push = 1'b1;
          sp_d = sp_inc;
          if (!full) lvl_d = lvl_q + LVL_W'(1);
`endif
        end
        OP_RETURN: begin
`ifdef PC_STACK_GUARD_EN
          if (empty) begin
            pc_d  = RESET_VECTOR;
            unf_d = 1'b1;
          end else begin
            sp_d  = sp_dec;
            pc_d  = stack_q[sp_dec];
            lvl_d = lvl_q - LVL_W'(1);
          end
`else
          sp_d = sp_dec;
          pc_d = stack_q[sp_dec];
          if (!empty) lvl_d = lvl_q - LVL_W'(1);
`endif
        end
        OP_LOAD_LOW: pc_d = pc_masked;
        OP_SOFT_RST: pc_d = RESET_VECTOR;
        default:     pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      sp_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push) stack_q[sp_q] <= pc_inc;
    end
  end

  assign pc_out      = pc_q;
  assign stack_level = lvl_q;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;
endmodule
